// File: rtl/rotary_pkg.sv
// Shared definitions for the rotary parameter controller: FSM states and
// default parameter values.
package rotary_pkg;

    typedef enum logic [1:0] {
        ST_BROWSE = 2'd0,
        ST_EDIT   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    localparam int DEF_N_PARAM   = 4;
    localparam int DEF_W         = 8;
    localparam int DEF_MAX_VAL   = 200;
    localparam int DEF_RST_VAL   = 100;
    localparam int DEF_FAST_WIN  = 50000;
    localparam int DEF_FAST_STEP = 8;
    localparam int DEF_TIMEOUT   = 10000000;

endpackage

// File: rtl/rotary_param_ctrl_if.sv
// User-input and parameter-output bundle of the rotary parameter controller.
interface rotary_param_ctrl_if
    import rotary_pkg::*;
#(
    parameter int N_PARAM = DEF_N_PARAM,
    parameter int W       = DEF_W
);
    localparam int SEL_W = $clog2(N_PARAM);

    logic                   rot_event_i;
    logic                   rot_dir_i;
    logic                   btn_press_i;
    logic [SEL_W-1:0]       sel_o;
    logic                   edit_o;
    logic [W-1:0]           cur_o;
    logic [N_PARAM*W-1:0]   param_o;
    logic                   upd_o;
    logic [SEL_W-1:0]       upd_idx_o;

    modport master (
        output rot_event_i, rot_dir_i, btn_press_i,
        input  sel_o, edit_o, cur_o, param_o, upd_o, upd_idx_o
    );

    modport slave (
        input  rot_event_i, rot_dir_i, btn_press_i,
        output sel_o, edit_o, cur_o, param_o, upd_o, upd_idx_o
    );

endinterface

// File: rtl/rot_step_gen.sv
// Edit step generator: measures spacing between edit events and selects the
// accelerated step when events arrive quickly.
module rot_step_gen
    import rotary_pkg::*;
#(
    parameter int W         = DEF_W,
    parameter int FAST_WIN  = DEF_FAST_WIN,
    parameter int FAST_STEP = DEF_FAST_STEP
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic         evt_i,
    output logic [W-1:0] step_o
);
    localparam int CNT_W = $clog2(FAST_WIN + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             first_q, first_d;

    always_comb begin
        cnt_d   = cnt_q;
        first_d = first_q;
        if (start_i) begin
            cnt_d   = '0;
            first_d = 1'b1;
        end else if (evt_i) begin
            cnt_d   = '0;
            first_d = 1'b0;
        end else if (cnt_q != CNT_W'(FAST_WIN)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // cnt_q holds (spacing - 1) at the next event, hence the FAST_WIN-1 bound
    assign step_o = (!first_q && (cnt_q < CNT_W'(FAST_WIN - 1))) ? W'(FAST_STEP) : W'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            first_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            first_q <= first_d;
        end
    end

endmodule

// File: rtl/rotary_param_ctrl.sv
// Rotary-encoder parameter editor: browse a bank of registers, edit one in a
// shadow copy with acceleration and saturation, then commit or time out.
module rotary_param_ctrl
    import rotary_pkg::*;
#(
    parameter int N_PARAM   = DEF_N_PARAM,
    parameter int W         = DEF_W,
    parameter int MAX_VAL   = DEF_MAX_VAL,
    parameter int RST_VAL   = DEF_RST_VAL,
    parameter int FAST_WIN  = DEF_FAST_WIN,
    parameter int FAST_STEP = DEF_FAST_STEP,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                CLK_i,
    input  logic                RST_N_i,
    rotary_param_ctrl_if.slave  bus
);
    localparam int SEL_W = $clog2(N_PARAM);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [W:0]   MAX_X = (W + 1)'(MAX_VAL);
    localparam logic [W-1:0] MAX_V = W'(MAX_VAL);

    state_e                    state_q, state_d;
    logic [SEL_W-1:0]          sel_q, sel_d, upd_idx_q, upd_idx_d;
    logic [W-1:0]              shadow_q, shadow_d, cur_q, cur_d, step;
    logic [N_PARAM-1:0][W-1:0] param_q, param_d;
    logic [TO_W-1:0]           idle_q, idle_d;
    logic                      edit_q, edit_d, upd_q, upd_d;
    logic                      step_start, step_evt;

    function automatic logic [W-1:0] sat_step(input logic [W-1:0] v,
                                              input logic [W-1:0] s,
                                              input logic         up);
        logic [W:0] sum;
        sum = {1'b0, v} + {1'b0, s};
        if (up)
            return (sum > MAX_X) ? MAX_V : sum[W-1:0];
        return (v < s) ? '0 : v - s;
    endfunction

    rot_step_gen #(
        .W         (W),
        .FAST_WIN  (FAST_WIN),
        .FAST_STEP (FAST_STEP)
    ) u_step (
        .clk_i   (CLK_i),
        .rst_ni  (RST_N_i),
        .start_i (step_start),
        .evt_i   (step_evt),
        .step_o  (step)
    );

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        shadow_d   = shadow_q;
        param_d    = param_q;
        idle_d     = idle_q;
        upd_d      = 1'b0;
        upd_idx_d  = upd_idx_q;
        step_start = 1'b0;
        step_evt   = 1'b0;
        case (state_q)
            ST_BROWSE: begin
                if (bus.btn_press_i) begin
                    shadow_d   = param_q[sel_q];
                    idle_d     = '0;
                    step_start = 1'b1;
                    state_d    = ST_EDIT;
                end else if (bus.rot_event_i) begin
                    // N_PARAM is a power of two, so natural overflow wraps
                    sel_d = bus.rot_dir_i ? sel_q + 1'b1 : sel_q - 1'b1;
                end
            end
            ST_EDIT: begin
                if (bus.btn_press_i) begin
                    state_d = ST_COMMIT;
                end else if (bus.rot_event_i) begin
                    shadow_d = sat_step(shadow_q, step, bus.rot_dir_i);
                    idle_d   = '0;
                    step_evt = 1'b1;
                end else if (idle_q == TO_W'(TIMEOUT - 1)) begin
                    state_d = ST_BROWSE;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            ST_COMMIT: begin
                param_d[sel_q] = shadow_q;
                upd_d          = 1'b1;
                upd_idx_d      = sel_q;
                state_d        = ST_BROWSE;
            end
            default: state_d = ST_BROWSE;
        endcase
        edit_d = (state_d == ST_EDIT);
        cur_d  = edit_d ? shadow_d : param_d[sel_d];
    end

    always_ff @(posedge CLK_i or negedge RST_N_i) begin
        if (!RST_N_i) begin
            state_q   <= ST_BROWSE;
            sel_q     <= '0;
            shadow_q  <= '0;
            idle_q    <= '0;
            edit_q    <= 1'b0;
            cur_q     <= W'(RST_VAL);
            upd_q     <= 1'b0;
            upd_idx_q <= '0;
            for (int i = 0; i < N_PARAM; i++) param_q[i] <= W'(RST_VAL);
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            shadow_q  <= shadow_d;
            idle_q    <= idle_d;
            edit_q    <= edit_d;
            cur_q     <= cur_d;
            upd_q     <= upd_d;
            upd_idx_q <= upd_idx_d;
            param_q   <= param_d;
        end
    end

    assign bus.sel_o     = sel_q;
    assign bus.edit_o    = edit_q;
    assign bus.cur_o     = cur_q;
    assign bus.param_o   = param_q;
    assign bus.upd_o     = upd_q;
    assign bus.upd_idx_o = upd_idx_q;

endmodule

// File: tb/tb_rotary_param_ctrl.sv
// Bench for rotary_param_ctrl: directed scenarios plus random input traffic,
// all checked every cycle against a cycle-stamped behavioural model.
module tb_rotary_param_ctrl;

    localparam int N         = 4;
    localparam int W         = 8;
    localparam int MAX_VAL   = 200;
    localparam int RST_VAL   = 100;
    localparam int FAST_WIN  = 50;
    localparam int FAST_STEP = 8;
    localparam int TIMEOUT   = 200;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    rotary_param_ctrl_if #(.N_PARAM(N), .W(W)) bus ();

    rotary_param_ctrl #(
        .N_PARAM   (N),
        .W         (W),
        .MAX_VAL   (MAX_VAL),
        .RST_VAL   (RST_VAL),
        .FAST_WIN  (FAST_WIN),
        .FAST_STEP (FAST_STEP),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .CLK_i   (clk),
        .RST_N_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference model: modes 0=browse 1=edit 2=commit, times are edge numbers
    int m_mode, m_sel, m_shadow, m_upd, m_upd_idx, m_cyc, m_last_evt, m_last_act;
    int m_param [N];
    bit m_prev;

    function void model_reset();
        m_mode = 0; m_sel = 0; m_shadow = 0; m_upd = 0; m_upd_idx = 0;
        m_last_evt = 0; m_last_act = 0; m_prev = 1'b0;
        for (int i = 0; i < N; i++) m_param[i] = RST_VAL;
    endfunction

    function void model_step(bit rot, bit dir, bit btn);
        int step;
        m_cyc++;
        m_upd = 0;
        if (m_mode == 0) begin
            if (btn) begin
                m_shadow = m_param[m_sel]; m_mode = 1; m_prev = 1'b0; m_last_act = m_cyc;
            end else if (rot) begin
                m_sel = dir ? (m_sel + 1) % N : (m_sel + N - 1) % N;
            end
        end else if (m_mode == 1) begin
            if (btn) begin
                m_mode = 2;
            end else if (rot) begin
                step = (m_prev && (m_cyc - m_last_evt) < FAST_WIN) ? FAST_STEP : 1;
                if (dir) m_shadow = (m_shadow + step > MAX_VAL) ? MAX_VAL : m_shadow + step;
                else     m_shadow = (m_shadow - step < 0) ? 0 : m_shadow - step;
                m_prev = 1'b1; m_last_evt = m_cyc; m_last_act = m_cyc;
            end else if (m_cyc - m_last_act >= TIMEOUT) begin
                m_mode = 0;
            end
        end else begin
            m_param[m_sel] = m_shadow; m_upd = 1; m_upd_idx = m_sel; m_mode = 0;
        end
    endfunction

    function logic [N*W-1:0] m_packed();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = m_param[i][W-1:0];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("m_sel", bus.sel_o, m_sel);
        chk("m_edit", bus.edit_o, m_mode == 1);
        chk("m_cur", bus.cur_o, (m_mode == 1) ? m_shadow : m_param[m_sel]);
        chk("m_upd", bus.upd_o, m_upd);
        if (m_upd != 0) chk("m_upd_idx", bus.upd_idx_o, m_upd_idx);
        chk("m_param", bus.param_o, m_packed());
    endtask

    // Called at a falling edge; returns at the next falling edge
    task automatic cyc(input bit rot, input bit dir, input bit btn);
        bus.rot_event_i = rot;
        bus.rot_dir_i   = dir;
        bus.btn_press_i = btn;
        @(posedge clk);
        model_step(rot, dir, btn);
        @(negedge clk);
        bus.rot_event_i = 1'b0;
        bus.btn_press_i = 1'b0;
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_sel"}, bus.sel_o, 0);
        chk({tag, "_edit"}, bus.edit_o, 0);
        chk({tag, "_upd"}, bus.upd_o, 0);
        chk({tag, "_upd_idx"}, bus.upd_idx_o, 0);
        chk({tag, "_cur"}, bus.cur_o, RST_VAL);
        chk({tag, "_param"}, bus.param_o, {N{8'(RST_VAL)}});
    endtask

    initial begin
        int dens, r;
        bus.rot_event_i = 1'b0;
        bus.rot_dir_i   = 1'b0;
        bus.btn_press_i = 1'b0;
        m_cyc = 0;
        model_reset();

        // Power-on reset
        repeat (3) @(negedge clk);
        chk_reset_state("por");
        rst_n = 1'b1;

        // Browse wrap right and left
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
            chk($sformatf("browse_r%0d", i), bus.sel_o, i % N);
        end
        cyc(1'b1, 1'b0, 1'b0);
        chk("browse_l_to0", bus.sel_o, 0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("browse_wrap_left", bus.sel_o, 3);
        cyc(1'b1, 1'b0, 1'b0);
        chk("browse_sel2", bus.sel_o, 2);

        // Slow edit of param 2 and commit
        cyc(1'b0, 1'b0, 1'b1);
        chk("edit_enter", bus.edit_o, 1);
        chk("edit_enter_cur", bus.cur_o, 100);
        for (int k = 0; k < 3; k++) begin
            idle(59);
            cyc(1'b1, 1'b1, 1'b0);
            chk($sformatf("slow_cur%0d", k), bus.cur_o, 101 + k);
        end
        cyc(1'b0, 1'b0, 1'b1);
        chk("commit_edit_low", bus.edit_o, 0);
        chk("commit_upd_low", bus.upd_o, 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("commit_upd", bus.upd_o, 1);
        chk("commit_upd_idx", bus.upd_idx_o, 2);
        chk("commit_param2", bus.param_o[2*W +: W], 103);
        cyc(1'b0, 1'b0, 1'b0);
        chk("commit_upd_once", bus.upd_o, 0);

        // Bring param 1 to 198 with fast then slow steps
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0);
        chk("first_step_one", bus.cur_o, 101);
        for (int k = 0; k < 12; k++) begin
            idle(9);
            cyc(1'b1, 1'b1, 1'b0);
        end
        chk("fast_steps", bus.cur_o, 197);
        idle(59);
        cyc(1'b1, 1'b1, 1'b0);
        chk("slow_after_fast", bus.cur_o, 198);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("param1_198", bus.param_o[1*W +: W], 198);

        // Saturation at MAX_VAL and at zero
        cyc(1'b0, 1'b0, 1'b1);
        chk("sat_enter_cur", bus.cur_o, 198);
        idle(9);
        cyc(1'b1, 1'b1, 1'b0);
        chk("sat_r1", bus.cur_o, 199);
        idle(9);
        cyc(1'b1, 1'b1, 1'b0);
        chk("sat_r2", bus.cur_o, 200);
        idle(9);
        cyc(1'b1, 1'b1, 1'b0);
        chk("sat_r3", bus.cur_o, 200);
        for (int k = 0; k < 30; k++) begin
            idle(9);
            cyc(1'b1, 1'b0, 1'b0);
            if (k == 0) chk("sat_l1", bus.cur_o, 192);
        end
        chk("sat_floor", bus.cur_o, 0);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("param1_zero", bus.param_o[1*W +: W], 0);

        // Timeout discards the shadow
        cyc(1'b1, 1'b0, 1'b0);
        chk("to_sel0", bus.sel_o, 0);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0);
        chk("to_cur", bus.cur_o, 101);
        idle(TIMEOUT - 1);
        chk("to_still_edit", bus.edit_o, 1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("to_edit_low", bus.edit_o, 0);
        chk("to_no_upd", bus.upd_o, 0);
        chk("to_param0", bus.param_o[0 +: W], 100);
        chk("to_cur_back", bus.cur_o, 100);
        idle(3);

        // Button wins over rotation; inputs during COMMIT ignored
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        chk("both_commit", bus.edit_o, 0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("both_upd", bus.upd_o, 1);
        chk("both_param0", bus.param_o[0 +: W], 101);
        chk("commit_ignores_rot", bus.sel_o, 0);

        // Asynchronous reset in the middle of an edit
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_state("mid_edit_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);

        // Random traffic with varying event density
        for (int blk = 0; blk < 20; blk++) begin
            dens = $urandom_range(0, 3);
            for (int i = 0; i < 100; i++) begin
                r = $urandom_range(0, 99);
                cyc((dens == 1 && r < 3) || (dens == 2 && r < 12) || (dens == 3 && r < 45),
                    1'($urandom_range(0, 1)),
                    (dens != 0) && ($urandom_range(0, 99) < 4));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
